// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: request front-end for a single-port synchronous RAM.
// Arbitrates independent write and read request streams onto one registered
// RAM port. Read data returns through a small response FIFO, and a credit
// scheme stops the RAM pipeline from overrunning that FIFO.
// Optional feature: define RAM_ARB_RR_EN for round-robin arbitration when
// both streams request in the same cycle. By default writes have fixed priority.
module ram_access_ctrl #(
    parameter int AW        = 6,
    parameter int DW        = 8,
    parameter int RSP_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_valid,
    output logic          rd_ready,
    input  logic [AW-1:0] rd_addr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic [DW-1:0] ram_data,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q
);

    localparam int PW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNTW = $clog2(RSP_DEPTH + 1);
    localparam int SUMW = $clog2(RSP_DEPTH + 3);

    typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_RD} gnt_e;

    gnt_e            gnt;
    logic            rd_ok;
    logic [SUMW-1:0] credit_used;

    logic            ram_we_q, ram_we_d;
    logic [AW-1:0]   ram_addr_q, ram_addr_d;
    logic [DW-1:0]   ram_data_q, ram_data_d;
    logic            s1_q, s1_d;
    logic            s2_q, s2_d;

    logic [DW-1:0]   fifo_mem [RSP_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A read is allowed only if every read already in the RAM pipeline or in
    // the FIFO still leaves space for it. All terms are registered, so rsp_ready
    // has no path to rd_ready.
    assign credit_used = SUMW'(s1_q) + SUMW'(s2_q) + SUMW'(cnt_q);
    assign rd_ok       = credit_used < SUMW'(RSP_DEPTH);

`ifdef RAM_ARB_RR_EN
    // rr_q = 1 means a read gets priority at the next conflict.
    logic rr_q, rr_d;

    // Round-robin arbitration. The pointer moves only on cycles with a conflict.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
        gnt  = GNT_NONE;
        rr_d = rr_q;
        if (wr_valid && rd_valid) begin
            gnt  = (rr_q && rd_ok) ? GNT_RD : GNT_WR;
            rr_d = (gnt == GNT_WR);
        end else if (wr_valid) begin
            gnt = GNT_WR;
        end else if (rd_valid && rd_ok) begin
            gnt = GNT_RD;
        end
    end

    // Round-robin pointer. After reset it favours writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= 1'b0;
        else        rr_q <= rr_d;
    end
`else
    // Fixed write priority. A read is granted only when no write is presented.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
        gnt = GNT_NONE;
        if (wr_valid)                gnt = GNT_WR;
        else if (rd_valid && rd_ok)  gnt = GNT_RD;
    end
`endif

    assign wr_ready = (gnt == GNT_WR);
    assign rd_ready = (gnt == GNT_RD);

    // Next-state logic for the RAM port registers and the read-tracking pipe.
    always_comb begin
        ram_we_d   = (gnt == GNT_WR);
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        s1_d       = (gnt == GNT_RD);
        s2_d       = s1_q;
        case (gnt)
            GNT_WR: begin
                ram_addr_d = wr_addr;
                ram_data_d = wr_data;
            end
            GNT_RD:  ram_addr_d = rd_addr;
            default: ;
        endcase
    end

    // RAM port and in-flight registers. Reset drops any write that has not yet
    // reached the RAM, and any reads that are in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (!rst_n) begin
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
        end else begin
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_data = ram_data_q;

    // Response FIFO control. ram_q is valid during the cycle in which s2 is set.
    assign push      = s2_q;
    assign rsp_valid = (cnt_q != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = fifo_mem[rd_ptr_q];

    // FIFO pointer and occupancy next state. Push and pop can happen together.
    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CNTW'(push) - CNTW'(pop);
    end

    // FIFO pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // FIFO storage. Only the pointers decide which entries are valid.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; clearing the pointers is enough to empty the FIFO.
        if (push) fifo_mem[wr_ptr_q] <= ram_q;
    end

    // The credit rule should make a push into a full FIFO impossible.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (cnt_q == CNTW'(RSP_DEPTH))));

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl with a behavioural 64x8 RAM attached.
// The reference model tracks accepted requests at transaction level. It keeps
// a shadow memory that is updated in acceptance order and a queue of expected
// responses, each with the cycle at which it becomes visible.
module tb_ram_access_ctrl;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LAT   = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid, wr_ready, rd_valid, rd_ready;
    logic [AW-1:0] wr_addr, rd_addr, ram_addr;
    logic [DW-1:0] wr_data, rsp_data, ram_data, ram_q;
    logic          rsp_valid, rsp_ready, ram_we;

    always #5 clk = ~clk;

    ram_access_ctrl #(.AW(AW), .DW(DW), .RSP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q)
    );

    // Behavioural synchronous single-port RAM. Reads return the old contents.
    logic [DW-1:0] ram_mem [2**AW];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_data;
        ram_q <= ram_mem[ram_addr];
    end

    // Reference model state.
    typedef struct { logic [DW-1:0] data; int ready_cyc; } exp_t;
    exp_t          exp_q[$];
    logic [DW-1:0] shadow [2**AW];
    logic [DW-1:0] got_q[$];
    int            cyc;
    bit            rr_rd_fav;
    bit            last_wr_fire;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_data;
    int            act_rd_cnt;
    bit            act_wr_fire;

    int tests = 0;
    int fails = 0;

    // Table-driven vectors: one row is one clock cycle.
    typedef struct {
        bit wv; logic [AW-1:0] wa; logic [DW-1:0] wd;
        bit rv; logic [AW-1:0] ra; bit rr;
        bit e_wr_rdy; bit e_rd_rdy; bit e_we; bit e_rsp_v; logic [DW-1:0] e_rsp_d;
    } vec_t;
    vec_t tbl [6];
    vec_t tv;
    bit   tv_active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle. The inputs are already driven. Outputs are checked at the
    // falling edge, and the model is updated at the rising edge.
    task automatic tick();
        bit rd_ok, g_wr, g_rd, e_rsp_v, pop;
        @(negedge clk);
        rd_ok = exp_q.size() < DEPTH;
        g_wr  = 1'b0;
        g_rd  = 1'b0;
        if (wr_valid && rd_valid) begin
`ifdef RAM_ARB_RR_EN
            g_rd = rr_rd_fav && rd_ok;
            g_wr = !g_rd;
`else
            g_wr = 1'b1;
`endif
        end else begin
            g_wr = wr_valid;
            g_rd = rd_valid && rd_ok;
        end
        check("wr_ready", wr_ready, g_wr);
        check("rd_ready", rd_ready, g_rd);
        check("ram_we", ram_we, last_wr_fire);
        check("ram_addr", ram_addr, last_addr);
        if (last_wr_fire) check("ram_data", ram_data, last_data);
        e_rsp_v = (exp_q.size() > 0) && (exp_q[0].ready_cyc <= cyc);
        check("rsp_valid", rsp_valid, e_rsp_v);
        if (e_rsp_v) check("rsp_data", rsp_data, exp_q[0].data);
        if (tv_active) begin
            check("tbl_wr_ready", wr_ready, tv.e_wr_rdy);
            check("tbl_rd_ready", rd_ready, tv.e_rd_rdy);
            check("tbl_ram_we", ram_we, tv.e_we);
            check("tbl_rsp_valid", rsp_valid, tv.e_rsp_v);
            if (tv.e_rsp_v) check("tbl_rsp_data", rsp_data, tv.e_rsp_d);
        end
        if (rsp_valid && rsp_ready) got_q.push_back(rsp_data);
        if (rd_valid && rd_ready) act_rd_cnt++;
        act_wr_fire = wr_valid && wr_ready;
        pop = e_rsp_v && rsp_ready;
        @(posedge clk);
        if (pop) void'(exp_q.pop_front());
        if (g_wr) shadow[wr_addr] = wr_data;
        if (g_rd) exp_q.push_back('{data: shadow[rd_addr], ready_cyc: cyc + LAT});
        if (wr_valid && rd_valid) rr_rd_fav = g_wr;
        last_wr_fire = g_wr;
        if (g_wr) begin
            last_addr = wr_addr;
            last_data = wr_data;
        end else if (g_rd) begin
            last_addr = rd_addr;
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reset can be asserted mid-cycle. Outputs must clear at once, and the model
    // drops every expected response.
    task automatic do_reset();
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_ram_addr", ram_addr, '0);
        exp_q.delete();
        rr_rd_fav    = 1'b0;
        last_wr_fire = 1'b0;
        last_addr    = '0;
        last_data    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        bit [5:0] pat;
        bit [5:0] pat_exp;
        int       acc;

        for (int i = 0; i < 2**AW; i++) begin
            ram_mem[i] = 8'(i * 7 + 3);
            shadow[i]  = 8'(i * 7 + 3);
        end
        cyc = 0; act_rd_cnt = 0; act_wr_fire = 1'b0;
        rst_n = 1'b1; rsp_ready = 1'b1;
        wr_valid = 1'b0; rd_valid = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        #2;
        do_reset();

        // Test 1: write 0x05=0xA5, then read 0x05 on the next cycle.
        tbl[0] = '{1, 6'h05, 8'hA5, 0, 6'h00, 1,  1, 0, 0, 0, 8'h00};
        tbl[1] = '{0, 6'h00, 8'h00, 1, 6'h05, 1,  0, 1, 1, 0, 8'h00};
        tbl[2] = '{0, 6'h00, 8'h00, 0, 6'h00, 1,  0, 0, 0, 0, 8'h00};
        tbl[3] = '{0, 6'h00, 8'h00, 0, 6'h00, 1,  0, 0, 0, 0, 8'h00};
        tbl[4] = '{0, 6'h00, 8'h00, 0, 6'h00, 1,  0, 0, 0, 1, 8'hA5};
        tbl[5] = '{0, 6'h00, 8'h00, 0, 6'h00, 1,  0, 0, 0, 0, 8'h00};
        for (int i = 0; i < 6; i++) begin
            tv        = tbl[i];
            wr_valid  = tv.wv; wr_addr = tv.wa; wr_data = tv.wd;
            rd_valid  = tv.rv; rd_addr = tv.ra; rsp_ready = tv.rr;
            tv_active = 1'b1;
            tick();
            tv_active = 1'b0;
        end
        idle(2);

        // Test 2: back-to-back reads of every address.
        got_q.delete();
        for (int a = 0; a < 2**AW; a++) begin
            rd_valid = 1'b1;
            rd_addr  = AW'(a);
            tick();
        end
        idle(6);
        check("t2_rsp_count", got_q.size(), 2**AW);
        for (int a = 0; a < 2**AW && a < got_q.size(); a++) check("t2_rsp_order", got_q[a], shadow[a]);

        // Test 3: back-pressure caps outstanding reads; draining resumes accepts.
        rsp_ready  = 1'b0;
        act_rd_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            rd_valid = 1'b1;
            rd_addr  = AW'(32 + act_rd_cnt);
            tick();
        end
        check("t3_accepts_capped", act_rd_cnt, DEPTH);
        check("t3_rd_ready_low", rd_ready, 1'b0);
        got_q.delete();
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_valid = 1'b1;
            rd_addr  = AW'(32 + act_rd_cnt);
            tick();
        end
        acc = act_rd_cnt;
        idle(6);
        check("t3_resumed", acc > DEPTH, 1'b1);
        for (int i = 0; i < DEPTH && i < got_q.size(); i++) check("t3_drain_order", got_q[i], shadow[32 + i]);

        // Test 4: both streams valid for 6 cycles, starting from reset.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1; wr_addr = AW'(48 + i); wr_data = 8'($urandom);
            rd_valid = 1'b1; rd_addr = 6'h38;
            tick();
            pat[i] = act_wr_fire;
        end
`ifdef RAM_ARB_RR_EN
        pat_exp = 6'b010101;
`else
        pat_exp = 6'b111111;
`endif
        check("t4_grant_pattern", pat, pat_exp);
        idle(6);

        // Test 5: a read followed by a write to the same address sees old data.
        wr_valid = 1'b1; wr_addr = 6'h10; wr_data = 8'h11; tick();
        idle(2);
        got_q.delete();
        rd_valid = 1'b1; rd_addr = 6'h10; tick();
        rd_valid = 1'b0; wr_valid = 1'b1; wr_addr = 6'h10; wr_data = 8'h22; tick();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 6'h10; tick();
        idle(6);
        check("t5_rsp_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("t5_old_data", got_q[0], 8'h11);
            check("t5_new_data", got_q[1], 8'h22);
        end

        // Test 6: reset with two reads in flight and two responses in the FIFO.
        rsp_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            rd_valid = 1'b1; rd_addr = AW'(i);
            tick();
        end
        rd_valid = 1'b0;
        check("t6_fifo_occupied", rsp_valid, 1'b1);
        do_reset();
        rsp_ready = 1'b1;
        got_q.delete();
        idle(8);
        check("t6_no_stale_rsp", got_q.size(), 0);

        // Randomized traffic, with addresses biased toward a few locations so
        // that read-after-write hazards occur often.
        for (int i = 0; i < 1500; i++) begin
            wr_valid  = ($urandom_range(0, 2) == 0);
            wr_addr   = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 3));
            wr_data   = 8'($urandom);
            rd_valid  = ($urandom_range(0, 1) == 0);
            rd_addr   = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 3));
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        rsp_ready = 1'b1;
        idle(8);
        check("final_drained", rsp_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
